uart_word_tx: RTL

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/ot_uart_pkg.sv | 16 +
 rtl/uart_word_tx_if.sv | 9 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_word_tx.sv | 98 +++++++++
 4 files changed

// File: rtl/ot_uart_pkg.sv
// Shared UART definitions: transmitter FSM state type, default bit timing
// and 8N1 frame constants.
package ot_uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int   CLKS_PER_BIT_DEF = 868;
  localparam logic START_BIT        = 1'b0;
  localparam logic STOP_BIT         = 1'b1;
  localparam int   DATA_BITS        = 8;
  localparam int   WORD_W           = 32;
endpackage

// File: rtl/uart_word_tx_if.sv
// Word handshake between a producer and the UART word transmitter.
interface uart_word_tx_if;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;

  modport master (output word_i, output word_valid_i, input  word_ready_o);
  modport slave  (input  word_i, input  word_valid_i, output word_ready_o);
endinterface

// File: rtl/uart_baud_tick.sv
// Per-bit tick generator: down-counter that fires once every CLKS_PER_BIT
// cycles, restarted synchronously so a new bit gets a full period.
module uart_baud_tick
  import ot_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic RsTx,
  input  logic restart,
  output logic tick
);
  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = cnt_q - CW'(1);
    if (restart || tick) cnt_d = RELOAD;
  end

  always_ff @(posedge clk or negedge RsTx) begin
    if (!RsTx) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_word_tx.sv
// Serializes one 32-bit word as BYTES_PER_WORD back-to-back 8N1 UART frames,
// least-significant byte first, with a one-cycle word_done_o pulse at the end.
module uart_word_tx
  import ot_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic           clk,
  input  logic           RsTx,
  uart_word_tx_if.slave  wif,
  output logic           tx_o,
  output logic           busy_o,
  output logic           word_done_o
);
  localparam int             BCW       = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);
  localparam int             BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic              done_q, done_d;
  logic              tick;

  // Holding the timer in reload while idle gives the start bit a full period.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .RsTx    (RsTx),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: if (wif.word_valid_i) begin
        shreg_d    = wif.word_i;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        state_d    = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        // Shifting right leaves the next byte in the low bits after 8 bits.
        shreg_d   = {1'b0, shreg_q[WORD_W-1:1]};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == LAST_BIT) state_d = STOP;
      end
      STOP: if (tick) begin
        if (byte_cnt_q == LAST_BYTE) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          done_d     = 1'b1;
        end else begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RsTx) begin
    if (!RsTx) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    tx_o = STOP_BIT;
    unique case (state_q)
      START:   tx_o = START_BIT;
      DATA:    tx_o = shreg_q[0];
      default: tx_o = STOP_BIT;
    endcase
  end

  assign wif.word_ready_o = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign word_done_o      = done_q;
endmodule
